// File: rtl/abc_pkg.sv
// Shared constants and state encoding for the abc input debouncer.
package abc_pkg;

    localparam int unsigned ABC_NUM_CH         = 3;
    localparam int unsigned ABC_STABLE_CNT_DEF = 4;
    localparam int unsigned ABC_CNT_W_DEF      = 8;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: optional 2-flop synchronizer, run counter, state bit, level register.
// Build option: ABC_DEBOUNCE_SYNC2_EN inserts the synchronizer ahead of the counter.
module debounce_ch
    import abc_pkg::*;
#(
    parameter int unsigned STABLE_CNT = ABC_STABLE_CNT_DEF,
    parameter int unsigned CNT_W      = ABC_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic x,
    output logic upd,
    output logic cnt_nz
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             s;
    logic [CNT_W-1:0] cnt;
    deb_state_e       state;

`ifdef ABC_DEBOUNCE_SYNC2_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign s = sync_q[1];
`else
    assign s = raw;
`endif

    // Request for the top-level chg strobe: this qualified edge accepts a new level.
    assign upd    = tick && (s != x) && (cnt == CNT_LAST);
    // PENDING exactly when the run counter is nonzero.
    assign cnt_nz = (state == ST_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= 1'b0;
            cnt   <= '0;
            state <= ST_STABLE;
        end else if (tick) begin
            if (s == x) begin
                cnt   <= '0;
                state <= ST_STABLE;
            end else if (cnt == CNT_LAST) begin
                x     <= s;
                cnt   <= '0;
                state <= ST_STABLE;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                state <= ST_PENDING;
            end
        end
    end

endmodule

// File: rtl/abc_input_debouncer.sv
// Three-channel debouncer feeding the abc logic cell; chg strobes once per conditioned-vector update.
// Build option: ABC_DEBOUNCE_SYNC2_EN adds a 2-flop synchronizer per channel (+2 clocks latency).
module abc_input_debouncer
    import abc_pkg::*;
#(
    parameter int unsigned STABLE_CNT = ABC_STABLE_CNT_DEF,
    parameter int unsigned CNT_W      = ABC_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw_a,
    input  logic raw_b,
    input  logic raw_c,
    output logic a,
    output logic b,
    output logic c,
    output logic chg,
    output logic busy
);

    logic [ABC_NUM_CH-1:0] raw_v;
    logic [ABC_NUM_CH-1:0] x_v;
    logic [ABC_NUM_CH-1:0] upd_v;
    logic [ABC_NUM_CH-1:0] nz_v;

    assign raw_v = {raw_c, raw_b, raw_a};

    for (genvar i = 0; i < ABC_NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .raw    (raw_v[i]),
            .x      (x_v[i]),
            .upd    (upd_v[i]),
            .cnt_nz (nz_v[i])
        );
    end

    assign a    = x_v[0];
    assign b    = x_v[1];
    assign c    = x_v[2];
    assign busy = |nz_v;

    // Simultaneous channel updates merge into a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg <= 1'b0;
        end else begin
            chg <= |upd_v;
        end
    end

endmodule

// File: tb/tb_abc_input_debouncer.sv
// Bench for abc_input_debouncer: history-window model checked every cycle plus directed literal checks.
module tb_abc_input_debouncer;

    localparam int unsigned STABLE = 4;
    localparam int unsigned HIST_MAX = 32;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic raw_a, raw_b, raw_c;
    logic a, b, c, chg, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    abc_input_debouncer #(.STABLE_CNT(STABLE), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw_a (raw_a),
        .raw_b (raw_b),
        .raw_c (raw_c),
        .a     (a),
        .b     (b),
        .c     (c),
        .chg   (chg),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last STABLE qualified samples since reset all differ from it.
    bit hist [3][$];
    bit mx   [3];
    bit mchg;

    function automatic bit window_differs(int ch);
        int n = hist[ch].size();
        if (n < int'(STABLE)) return 1'b0;
        for (int i = 0; i < int'(STABLE); i++)
            if (hist[ch][n-1-i] == mx[ch]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_busy();
        bit any = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            int n = hist[ch].size();
            if (n > 0 && hist[ch][n-1] != mx[ch]) any = 1'b1;
        end
        return any;
    endfunction

    always @(posedge clk) begin
        bit [2:0] rv;
        bit acc;
        rv = {raw_c, raw_b, raw_a};
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                hist[ch].delete();
                mx[ch] = 1'b0;
            end
            mchg = 1'b0;
        end else if (tick) begin
            acc = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                hist[ch].push_back(rv[ch]);
                if (hist[ch].size() > HIST_MAX) void'(hist[ch].pop_front());
                if (window_differs(ch)) begin
                    mx[ch] = ~mx[ch];
                    acc = 1'b1;
                end
            end
            mchg = acc;
        end else begin
            mchg = 1'b0;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("model_a",    a,    mx[0]);
            check("model_b",    b,    mx[1]);
            check("model_c",    c,    mx[2]);
            check("model_chg",  chg,  mchg);
            check("model_busy", busy, model_busy());
        end
    end

    task automatic step(input logic tk, input logic [2:0] rv);
        tick = tk;
        {raw_c, raw_b, raw_a} = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [2:0] abc, input logic ec, input logic eb);
        check({name, "_a"},    a,    abc[0]);
        check({name, "_b"},    b,    abc[1]);
        check({name, "_c"},    c,    abc[2]);
        check({name, "_chg"},  chg,  ec);
        check({name, "_busy"}, busy, eb);
    endtask

    initial begin
        logic [7:0] bpat;
        rst = 1'b1;
        tick = 1'b1;
        {raw_c, raw_b, raw_a} = 3'b111;

        // Reset with raw inputs high
        step(1'b1, 3'b111);
        started = 1'b1;
        step(1'b1, 3'b111);
        lit("reset", 3'b000, 1'b0, 1'b0);
        rst = 1'b0;

        // Clean change on a
        for (int e = 1; e <= 3; e++) begin
            step(1'b1, 3'b001);
            lit("clean_wait", 3'b000, 1'b0, 1'b1);
        end
        step(1'b1, 3'b001);
        lit("clean_e4", 3'b001, 1'b1, 1'b0);
        step(1'b1, 3'b001);
        lit("clean_e5", 3'b001, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) step(1'b1, 3'b000);
        lit("clean_back", 3'b000, 1'b0, 1'b0);

        // Bounce on b: pattern over edges 1..8 (bit 0 first)
        bpat = 8'b1111_0111;
        for (int e = 0; e < 7; e++) begin
            step(1'b1, {1'b0, bpat[e], 1'b0});
            check("bounce_b", b, 1'b0);
            check("bounce_chg", chg, 1'b0);
        end
        step(1'b1, 3'b010);
        lit("bounce_e8", 3'b010, 1'b1, 1'b0);
        for (int e = 0; e < 5; e++) step(1'b1, 3'b000);

        // Simultaneous a and c
        for (int e = 1; e <= 3; e++) begin
            step(1'b1, 3'b101);
            lit("simul_wait", 3'b000, 1'b0, 1'b1);
        end
        step(1'b1, 3'b101);
        lit("simul_e4", 3'b101, 1'b1, 1'b0);
        step(1'b1, 3'b101);
        lit("simul_e5", 3'b101, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) step(1'b1, 3'b000);

        // Tick gating: ticks on clocks 3,6,9,12
        for (int k = 1; k <= 11; k++) begin
            step((k % 3) == 0, 3'b100);
            check("tick_c", c, 1'b0);
            check("tick_chg", chg, 1'b0);
            if (k >= 3) check("tick_busy_hold", busy, 1'b1);
        end
        step(1'b1, 3'b100);
        lit("tick_k12", 3'b100, 1'b1, 1'b0);
        step(1'b0, 3'b100);
        lit("tick_k13", 3'b100, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) step(1'b1, 3'b000);

        // Reset mid-PENDING
        for (int e = 0; e < 3; e++) step(1'b1, 3'b001);
        lit("rstmid_pend", 3'b000, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 3'b001);
        lit("rstmid_rst", 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step(1'b1, 3'b001);
            lit("rstmid_wait", 3'b000, 1'b0, 1'b1);
        end
        step(1'b1, 3'b001);
        lit("rstmid_e4", 3'b001, 1'b1, 1'b0);
        for (int e = 0; e < 5; e++) step(1'b1, 3'b000);

        // Fast toggle never propagates
        for (int e = 0; e < 12; e++) step(1'b1, (e % 2) ? 3'b000 : 3'b111);
        lit("toggle", 3'b000, 1'b0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
